// File: rtl/chip8_pkg.sv
// Shared Chip-8 memory constants, loader state encoding and loader error codes.
package chip8_pkg;

    localparam int unsigned       MEM_AW    = 12;
    localparam logic [MEM_AW-1:0] PROG_BASE = 12'h200;
    localparam int unsigned       PROG_MAX  = 3584;

    // Loader state encoding, kept as plain constants for legacy compatibility
    typedef logic [2:0] ld_state_t;
    localparam ld_state_t ST_IDLE   = 3'd0;
    localparam ld_state_t ST_HDR_HI = 3'd1;
    localparam ld_state_t ST_HDR_LO = 3'd2;
    localparam ld_state_t ST_LOAD   = 3'd3;
    localparam ld_state_t ST_DONE   = 3'd4;
    localparam ld_state_t ST_FAIL   = 3'd5;
    localparam ld_state_t ST_CLEAR  = 3'd6;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    function automatic logic len_ok(input logic [15:0] len, input int unsigned max_len);
        return (len != 16'd0) && (32'(len) <= max_len);
    endfunction

endpackage

// File: rtl/game_loader_timeout.sv
// Saturating idle counter for the loader; expired holds while the count sits at LIMIT.
module loader_timeout #(
    parameter int unsigned      WIDTH = 24,
    parameter logic [WIDTH-1:0] LIMIT = '1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && (count != LIMIT)) begin
            count <= count + WIDTH'(1);
        end
    end

    always_comb begin
        expired = (count == LIMIT);
    end

endmodule

// File: rtl/game_loader.sv
// Chip-8 program loader: length-prefixed byte stream into memory port A from LOAD_BASE.
// Define GAME_LOADER_CLEAR_EN to zero 0x200..0xFFF before the payload is written.
module game_loader
    import chip8_pkg::*;
#(
    parameter logic [MEM_AW-1:0] LOAD_BASE      = PROG_BASE,
    parameter int unsigned       MAX_LEN        = PROG_MAX,
    parameter logic [23:0]       TIMEOUT_CYCLES = 24'd10_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_en,
    output logic              mem_write,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [7:0]        mem_in,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic [1:0]        error
);

    ld_state_t         state;
    logic [7:0]        len_hi;
    logic [MEM_AW-1:0] addr;
    logic [MEM_AW-1:0] remaining;
    logic [15:0]       hdr_len;
    logic              xfer;
    logic              tmo_clr;
    logic              expired;

    always_comb begin
        in_ready = (state == ST_HDR_HI) || (state == ST_HDR_LO) || (state == ST_LOAD);
        xfer     = in_valid && in_ready;
        hdr_len  = {len_hi, in_data};
        // Counter is frozen (neither counting nor cleared) in CLEAR
        tmo_clr  = xfer || (state == ST_IDLE) || (state == ST_DONE) || (state == ST_FAIL);
    end

    loader_timeout #(
        .WIDTH (24),
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (tmo_clr),
        .enable  (in_ready),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            len_hi    <= '0;
            addr      <= '0;
            remaining <= '0;
            mem_en    <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_in    <= '0;
            cpu_hold  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= ERR_NONE;
        end else begin
            mem_en    <= 1'b0;
            mem_write <= 1'b0;
            case (state)
                ST_IDLE, ST_FAIL: begin
                    if (start) begin
                        done     <= 1'b0;
                        error    <= ERR_NONE;
                        cpu_hold <= 1'b1;
                        busy     <= 1'b1;
                        state    <= ST_HDR_HI;
                    end else if (state == ST_IDLE) begin
                        cpu_hold <= 1'b0;
                    end
                end
                ST_HDR_HI: begin
                    if (xfer) begin
                        len_hi <= in_data;
                        state  <= ST_HDR_LO;
                    end else if (expired) begin
                        error <= ERR_TIMEOUT;
                        busy  <= 1'b0;
                        state <= ST_FAIL;
                    end
                end
                ST_HDR_LO: begin
                    if (xfer) begin
                        if (!len_ok(hdr_len, MAX_LEN)) begin
                            error <= ERR_LEN;
                            busy  <= 1'b0;
                            state <= ST_FAIL;
                        end else begin
                            addr      <= LOAD_BASE;
                            remaining <= hdr_len[MEM_AW-1:0];
`ifdef GAME_LOADER_CLEAR_EN
                            state     <= ST_CLEAR;
`else
                            state     <= ST_LOAD;
`endif
                        end
                    end else if (expired) begin
                        error <= ERR_TIMEOUT;
                        busy  <= 1'b0;
                        state <= ST_FAIL;
                    end
                end
`ifdef GAME_LOADER_CLEAR_EN
                ST_CLEAR: begin
                    mem_en    <= 1'b1;
                    mem_write <= 1'b1;
                    mem_addr  <= addr;
                    mem_in    <= '0;
                    if (addr == '1) begin
                        addr  <= LOAD_BASE;
                        state <= ST_LOAD;
                    end else begin
                        addr <= addr + MEM_AW'(1);
                    end
                end
`endif
                ST_LOAD: begin
                    if (xfer) begin
                        mem_en    <= 1'b1;
                        mem_write <= 1'b1;
                        mem_addr  <= addr;
                        mem_in    <= in_data;
                        addr      <= addr + MEM_AW'(1);
                        remaining <= remaining - MEM_AW'(1);
                        if (remaining == MEM_AW'(1)) begin
                            state <= ST_DONE;
                        end
                    end else if (expired) begin
                        error <= ERR_TIMEOUT;
                        busy  <= 1'b0;
                        state <= ST_FAIL;
                    end
                end
                ST_DONE: begin
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    cpu_hold <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
